// File: rtl/cs3220_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs3220_isa_pkg
// Brief    : Opcodes, altops, execute FSM states and helpers for execute_stage
// Revision : 1.0 - initial release
// ============================================================================
package cs3220_isa_pkg;

    localparam logic [5:0] c_op_bubble = 6'd0;
    localparam logic [5:0] c_op_alur   = 6'd1;
    localparam logic [5:0] c_op_alui   = 6'd2;
    localparam logic [5:0] c_op_mul    = 6'd3;
    localparam logic [5:0] c_op_lw     = 6'd4;
    localparam logic [5:0] c_op_sw     = 6'd5;
    localparam logic [5:0] c_op_cmpr   = 6'd6;
    localparam logic [5:0] c_op_cmpi   = 6'd7;
    localparam logic [5:0] c_op_br     = 6'd8;
    localparam logic [5:0] c_op_jal    = 6'd9;

    localparam logic [7:0] c_alu_add  = 8'd0;
    localparam logic [7:0] c_alu_sub  = 8'd1;
    localparam logic [7:0] c_alu_and  = 8'd2;
    localparam logic [7:0] c_alu_or   = 8'd3;
    localparam logic [7:0] c_alu_xor  = 8'd4;
    localparam logic [7:0] c_alu_nand = 8'd5;
    localparam logic [7:0] c_alu_nor  = 8'd6;
    localparam logic [7:0] c_alu_xnor = 8'd7;

    localparam logic [7:0] c_cmp_eq = 8'd0;
    localparam logic [7:0] c_cmp_ne = 8'd1;
    localparam logic [7:0] c_cmp_lt = 8'd2;
    localparam logic [7:0] c_cmp_le = 8'd3;

    // Branch/JAL immediates are word offsets
    localparam int c_br_shift = 2;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_DONE = 2'd2
    } ex_state_t;

    function automatic logic [31:0] alu_eval(input logic [7:0] altop,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (altop)
            c_alu_add:  r = a + b;
            c_alu_sub:  r = a - b;
            c_alu_and:  r = a & b;
            c_alu_or:   r = a | b;
            c_alu_xor:  r = a ^ b;
            c_alu_nand: r = ~(a & b);
            c_alu_nor:  r = ~(a | b);
            c_alu_xnor: r = ~(a ^ b);
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic logic cmp_eval(input logic [7:0] altop,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        logic r;
        r = 1'b0;
        case (altop)
            c_cmp_eq: r = (a == b);
            c_cmp_ne: r = (a != b);
            c_cmp_lt: r = ($signed(a) < $signed(b));
            c_cmp_le: r = ($signed(a) <= $signed(b));
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic writes_rd(input logic [5:0] op);
        return (op == c_op_alur) || (op == c_op_alui) || (op == c_op_mul) ||
               (op == c_op_cmpr) || (op == c_op_cmpi) || (op == c_op_lw)  ||
               (op == c_op_jal);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iter_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : iter_multiplier
// Brief    : Shift-add multiplier, one partial product per cycle, low 32 bits
// Revision : 1.0 - initial release
// ============================================================================
module iter_multiplier #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        last,
    output logic        done,
    output logic [31:0] product
);

    localparam int                 c_cnt_w = $clog2(MUL_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MUL_CYCLES - 1);

    logic [31:0]        r_mcand;
    logic [31:0]        r_mplier;
    logic [31:0]        r_acc;
    logic [c_cnt_w-1:0] r_count;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + c_cnt_w'(1);
            if (r_count == c_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign busy    = r_busy;
    assign last    = r_busy && (r_count == c_last);
    assign done    = r_done;
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : ALU/compare/branch/JAL resolution, iterative multiply, forwarding
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage
    import cs3220_isa_pkg::*;
#(
    parameter int          MUL_CYCLES = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] rr_pc,
    input  logic [31:0] rr_pc_inc,
    input  logic [5:0]  rr_op,
    input  logic [7:0]  rr_altop,
    input  logic [3:0]  rr_rd,
    input  logic [31:0] rr_rs_val,
    input  logic [31:0] rr_rt_val,
    input  logic [31:0] rr_imm32,
    input  logic        rr_next_is_cont,
    input  logic        mem_stall,
    output logic        exec_stall,
    output logic        exec_flush,
    output logic [31:0] exec_redirect_pc,
    output logic [31:0] ex_pc,
    output logic [5:0]  ex_op,
    output logic [3:0]  ex_rd,
    output logic        ex_wr_en,
    output logic [31:0] ex_result,
    output logic [31:0] ex_store_val,
    output logic [3:0]  fwd_a_addr,
    output logic [31:0] fwd_a_val
);

    ex_state_t   r_state;
    logic        w_mul_start;
    logic        w_mul_busy;
    logic        w_mul_last;
    logic        w_mul_done;
    logic [31:0] w_mul_product;

    logic [31:0] w_imm_sh;
    logic [31:0] w_br_target;
    logic [31:0] w_jal_target;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic [31:0] w_result;

    assign w_mul_start = (r_state == EX_IDLE) && (rr_op == c_op_mul) && !mem_stall;

    iter_multiplier #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk          (i_clk),
        .rst          (i_reset),
        .start        (w_mul_start),
        .multiplicand (rr_rs_val),
        .multiplier   (rr_rt_val),
        .busy         (w_mul_busy),
        .last         (w_mul_last),
        .done         (w_mul_done),
        .product      (w_mul_product)
    );

    // In DONE the stall follows mem_stall alone so the product can retire
    assign exec_stall = mem_stall || w_mul_busy ||
                        ((r_state == EX_IDLE) && (rr_op == c_op_mul));

    assign w_imm_sh     = rr_imm32 << c_br_shift;
    assign w_br_target  = rr_pc_inc + w_imm_sh;
    assign w_jal_target = rr_rs_val + w_imm_sh;
    assign w_taken      = ((rr_op == c_op_br) && cmp_eval(rr_altop, rr_rs_val, rr_rt_val)) ||
                          (rr_op == c_op_jal);
    assign w_target     = (rr_op == c_op_jal) ? w_jal_target : w_br_target;
    assign w_next_pc    = w_taken ? w_target : rr_pc_inc;

    // Fetch's guess is only wrong if it didn't continue sequentially or the target moved
    assign exec_flush = (rr_op != c_op_bubble) && !exec_stall &&
                        (!rr_next_is_cont || (w_taken && (w_target != rr_pc_inc)));
    assign exec_redirect_pc = exec_flush ? w_next_pc : RESET_PC;

    always_comb begin
        w_result = '0;
        case (rr_op)
            c_op_alur:         w_result = alu_eval(rr_altop, rr_rs_val, rr_rt_val);
            c_op_alui:         w_result = alu_eval(rr_altop, rr_rs_val, rr_imm32);
            c_op_lw, c_op_sw:  w_result = rr_rs_val + rr_imm32;
            c_op_cmpr:         w_result = {31'd0, cmp_eval(rr_altop, rr_rs_val, rr_rt_val)};
            c_op_cmpi:         w_result = {31'd0, cmp_eval(rr_altop, rr_rs_val, rr_imm32)};
            c_op_br:           w_result = w_br_target;
            c_op_jal:          w_result = rr_pc_inc;
            default:           w_result = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= EX_IDLE;
            ex_pc        <= '0;
            ex_op        <= '0;
            ex_rd        <= '0;
            ex_wr_en     <= 1'b0;
            ex_result    <= '0;
            ex_store_val <= '0;
        end else begin
            case (r_state)
                EX_IDLE: begin
                    if (!mem_stall) begin
                        ex_pc        <= rr_pc;
                        ex_rd        <= rr_rd;
                        ex_store_val <= rr_rt_val;
                        if (rr_op == c_op_mul) begin
                            // Memory stage sees bubbles while the product is built
                            r_state   <= EX_MUL;
                            ex_op     <= c_op_bubble;
                            ex_wr_en  <= 1'b0;
                            ex_result <= '0;
                        end else begin
                            ex_op     <= rr_op;
                            ex_wr_en  <= writes_rd(rr_op);
                            ex_result <= w_result;
                        end
                    end
                end
                EX_MUL: begin
                    if (w_mul_last) begin
                        r_state <= EX_DONE;
                    end
                    if (!mem_stall) begin
                        ex_op     <= c_op_bubble;
                        ex_wr_en  <= 1'b0;
                        ex_result <= '0;
                    end
                end
                EX_DONE: begin
                    if (!mem_stall && w_mul_done) begin
                        r_state      <= EX_IDLE;
                        ex_pc        <= rr_pc;
                        ex_op        <= rr_op;
                        ex_rd        <= rr_rd;
                        ex_wr_en     <= 1'b1;
                        ex_result    <= w_mul_product;
                        ex_store_val <= rr_rt_val;
                    end
                end
                default: r_state <= EX_IDLE;
            endcase
        end
    end

    assign fwd_a_addr = ex_wr_en ? ex_rd : 4'd0;
    assign fwd_a_val  = ex_wr_en ? ex_result : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Randomized scoreboard bench for execute_stage against an ISA model
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;
    import cs3220_isa_pkg::*;

    localparam int          MUL_CYCLES = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic [31:0] rr_pc, rr_pc_inc, rr_rs_val, rr_rt_val, rr_imm32;
    logic [5:0]  rr_op;
    logic [7:0]  rr_altop;
    logic [3:0]  rr_rd;
    logic        rr_next_is_cont, mem_stall;
    logic        exec_stall, exec_flush, ex_wr_en;
    logic [31:0] exec_redirect_pc, ex_pc, ex_result, ex_store_val, fwd_a_val;
    logic [5:0]  ex_op;
    logic [3:0]  ex_rd, fwd_a_addr;

    execute_stage #(.MUL_CYCLES(MUL_CYCLES), .RESET_PC(RESET_PC)) dut (
        .i_clk(clk), .i_reset(rst), .rr_pc(rr_pc), .rr_pc_inc(rr_pc_inc),
        .rr_op(rr_op), .rr_altop(rr_altop), .rr_rd(rr_rd),
        .rr_rs_val(rr_rs_val), .rr_rt_val(rr_rt_val), .rr_imm32(rr_imm32),
        .rr_next_is_cont(rr_next_is_cont), .mem_stall(mem_stall),
        .exec_stall(exec_stall), .exec_flush(exec_flush),
        .exec_redirect_pc(exec_redirect_pc), .ex_pc(ex_pc), .ex_op(ex_op),
        .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_result(ex_result),
        .ex_store_val(ex_store_val), .fwd_a_addr(fwd_a_addr), .fwd_a_val(fwd_a_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [3:0]  rd;
        logic        wr_en;
        logic [31:0] result;
        logic [31:0] store_val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic in_reset_seq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- ISA reference model ----------------
    function automatic logic [31:0] m_alu(input logic [7:0] alt, input logic [31:0] a, input logic [31:0] b);
        case (alt)
            8'd0: return a + b;
            8'd1: return a - b;
            8'd2: return a & b;
            8'd3: return a | b;
            8'd4: return a ^ b;
            8'd5: return ~(a & b);
            8'd6: return ~(a | b);
            8'd7: return ~(a ^ b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_cond(input logic [7:0] alt, input logic [31:0] a, input logic [31:0] b);
        int sa, sb_;
        sa  = int'(a);
        sb_ = int'(b);
        case (alt)
            8'd0: return sa == sb_;
            8'd1: return sa != sb_;
            8'd2: return sa < sb_;
            8'd3: return sa <= sb_;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_result(input logic [5:0] op, input logic [7:0] alt,
                                             input logic [31:0] pc, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] imm);
        case (op)
            c_op_alur: return m_alu(alt, rs, rt);
            c_op_alui: return m_alu(alt, rs, imm);
            c_op_mul:  return rs * rt;
            c_op_lw:   return rs + imm;
            c_op_sw:   return rs + imm;
            c_op_cmpr: return m_cond(alt, rs, rt) ? 32'd1 : 32'd0;
            c_op_cmpi: return m_cond(alt, rs, imm) ? 32'd1 : 32'd0;
            c_op_jal:  return pc + 32'd4;
            default:   return 32'd0;
        endcase
    endfunction

    // Presents one instruction and holds it until the stage accepts it.
    // mode 0: random mem_stall, 1: never stall, 2: stall the first 3 DONE cycles
    task automatic issue(input logic [5:0] op, input logic [7:0] alt, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                         input logic [3:0] rd, input logic cont, input int mode,
                         output int stall_cycles, output logic flush_seen,
                         output logic [31:0] redir_seen);
        int          prog, done_holds;
        logic        accepted, exp_stall, taken, exp_flush;
        logic [31:0] target, next_pc;
        exp_t        e;
        rr_pc = pc; rr_pc_inc = pc + 32'd4; rr_op = op; rr_altop = alt; rr_rd = rd;
        rr_rs_val = rs; rr_rt_val = rt; rr_imm32 = imm; rr_next_is_cont = cont;
        prog = 0; done_holds = 0; stall_cycles = 0; accepted = 1'b0;
        flush_seen = 1'b0; redir_seen = '0;
        taken   = (op == c_op_jal) || ((op == c_op_br) && m_cond(alt, rs, rt));
        target  = (op == c_op_jal) ? rs + imm * 4 : pc + 32'd4 + imm * 4;
        next_pc = taken ? target : pc + 32'd4;
        exp_flush = (op != c_op_bubble) && (!cont || (taken && target != pc + 32'd4));
        for (int cyc = 0; cyc < 300; cyc++) begin
            case (mode)
                0: mem_stall = ($urandom_range(0, 4) == 0);
                2: begin
                    mem_stall = (prog == MUL_CYCLES + 1) && (done_holds < 3);
                    if (mem_stall) done_holds++;
                end
                default: mem_stall = 1'b0;
            endcase
            @(negedge clk);
            exp_stall = mem_stall || (op == c_op_mul && prog <= MUL_CYCLES);
            chk("exec_stall", {31'd0, exec_stall}, {31'd0, exp_stall});
            if (exp_stall) begin
                stall_cycles++;
                chk("flush_while_stalled", {31'd0, exec_flush}, 32'd0);
                chk("redirect_idle", exec_redirect_pc, RESET_PC);
            end else begin
                chk("exec_flush", {31'd0, exec_flush}, {31'd0, exp_flush});
                chk("exec_redirect_pc", exec_redirect_pc, exp_flush ? next_pc : RESET_PC);
                flush_seen = exec_flush;
                redir_seen = exec_redirect_pc;
                if (op != c_op_bubble) begin
                    e.pc = pc; e.op = op; e.rd = rd; e.store_val = rt;
                    e.wr_en  = op inside {c_op_alur, c_op_alui, c_op_mul, c_op_cmpr,
                                          c_op_cmpi, c_op_lw, c_op_jal};
                    e.result = m_result(op, alt, pc, rs, rt, imm);
                    sb.push_back(e);
                end
            end
            if (op == c_op_mul) begin
                if (prog == 0) begin
                    if (!mem_stall) prog = 1;
                end else if (prog <= MUL_CYCLES) begin
                    prog++;
                end
            end
            @(posedge clk);
            #1;
            if (!exp_stall) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        stalled_edge;
        logic [31:0] p_pc, p_res, p_st;
        logic [5:0]  p_op;
        logic [3:0]  p_rd;
        logic        p_we;
        exp_t        e;
        p_pc = '0; p_res = '0; p_st = '0; p_op = '0; p_rd = '0; p_we = 1'b0;
        forever begin
            @(negedge clk);
            stalled_edge = mem_stall;
            @(posedge clk);
            #1;
            if (!in_reset_seq) begin
                if (stalled_edge) begin
                    chk("hold_pc_result", ex_pc ^ ex_result, p_pc ^ p_res);
                    chk("hold_ctrl", {17'd0, ex_op, ex_rd, ex_wr_en, 4'd0}, {17'd0, p_op, p_rd, p_we, 4'd0});
                    chk("hold_store", ex_store_val, p_st);
                end else if (ex_op != c_op_bubble) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output_op", {26'd0, ex_op}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ex_pc", ex_pc, e.pc);
                        chk("ex_op", {26'd0, ex_op}, {26'd0, e.op});
                        chk("ex_rd", {28'd0, ex_rd}, {28'd0, e.rd});
                        chk("ex_wr_en", {31'd0, ex_wr_en}, {31'd0, e.wr_en});
                        if (e.op != c_op_br) chk("ex_result", ex_result, e.result);
                        if (e.op == c_op_sw) chk("ex_store_val", ex_store_val, e.store_val);
                        chk("fwd_a_addr", {28'd0, fwd_a_addr}, e.wr_en ? {28'd0, e.rd} : 32'd0);
                        chk("fwd_a_val", fwd_a_val, e.wr_en ? e.result : 32'd0);
                    end
                end else begin
                    chk("bubble_wr_en", {31'd0, ex_wr_en}, 32'd0);
                    chk("bubble_fwd", {28'd0, fwd_a_addr} | fwd_a_val, 32'd0);
                end
            end
            p_pc = ex_pc; p_res = ex_result; p_st = ex_store_val;
            p_op = ex_op; p_rd = ex_rd; p_we = ex_wr_en;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ex_pc"}, ex_pc, 32'd0);
        chk({tag, "_ex_ctrl"}, {21'd0, ex_op, ex_rd, ex_wr_en}, 32'd0);
        chk({tag, "_ex_result"}, ex_result, 32'd0);
        chk({tag, "_ex_store"}, ex_store_val, 32'd0);
        chk({tag, "_fwd"}, {28'd0, fwd_a_addr} | fwd_a_val, 32'd0);
        chk({tag, "_stall"}, {31'd0, exec_stall}, 32'd0);
        chk({tag, "_flush"}, {31'd0, exec_flush}, 32'd0);
        chk({tag, "_redirect"}, exec_redirect_pc, RESET_PC);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          sc;
        logic        fl;
        logic [31:0] rd_pc, rs, rt, imm, pc;
        logic [5:0]  op;
        logic [7:0]  alt;
        in_reset_seq = 1'b1;
        rst = 1'b1; mem_stall = 1'b0; rr_op = '0; rr_altop = '0; rr_rd = '0;
        rr_pc = '0; rr_pc_inc = 32'd4; rr_rs_val = '0; rr_rt_val = '0; rr_imm32 = '0;
        rr_next_is_cont = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        in_reset_seq = 1'b0;

        // Wrapping ADD with forwarding
        issue(c_op_alur, c_alu_add, 32'h200, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd5, 1'b1, 1, sc, fl, rd_pc);
        chk("add_stall_cycles", sc, 32'd0);
        chk("add_result", ex_result, 32'd1);
        chk("add_fwd_addr", {28'd0, fwd_a_addr}, 32'd5);
        chk("add_fwd_val", fwd_a_val, 32'd1);

        // Multiply latency and product
        issue(c_op_mul, 8'd0, 32'h300, 32'd7, 32'h1000_0001, 32'd0, 4'd3, 1'b1, 1, sc, fl, rd_pc);
        chk("mul_stall_cycles", sc, 32'd33);
        chk("mul_result", ex_result, 32'h7000_0007);

        // Taken branch backwards
        issue(c_op_br, c_cmp_eq, 32'h100, 32'd9, 32'd9, 32'hFFFF_FFFE, 4'd0, 1'b1, 1, sc, fl, rd_pc);
        chk("br_taken_flush", {31'd0, fl}, 32'd1);
        chk("br_taken_redirect", rd_pc, 32'h0000_00FC);
        issue(c_op_bubble, 8'd0, 32'hFC, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1, sc, fl, rd_pc);
        chk("flush_one_cycle", {31'd0, fl}, 32'd0);

        // Not-taken branch, fetch did / did not continue sequentially
        issue(c_op_br, c_cmp_eq, 32'h40, 32'd1, 32'd2, 32'd8, 4'd0, 1'b0, 1, sc, fl, rd_pc);
        chk("br_nt_flush", {31'd0, fl}, 32'd1);
        chk("br_nt_redirect", rd_pc, 32'h44);
        issue(c_op_br, c_cmp_eq, 32'h40, 32'd1, 32'd2, 32'd8, 4'd0, 1'b1, 1, sc, fl, rd_pc);
        chk("br_nt_cont_flush", {31'd0, fl}, 32'd0);

        // mem_stall during DONE
        issue(c_op_mul, 8'd0, 32'h500, 32'h0001_0003, 32'h0000_0105, 32'd0, 4'd9, 1'b1, 2, sc, fl, rd_pc);
        chk("mul_done_stall_cycles", sc, 32'd36);
        chk("mul_done_result", ex_result, 32'h0105_030F);

        // Asynchronous reset in the middle of a multiply
        rr_pc = 32'h600; rr_pc_inc = 32'h604; rr_op = c_op_mul; rr_rs_val = 32'd5;
        rr_rt_val = 32'd6; rr_rd = 4'd4; rr_next_is_cont = 1'b1; mem_stall = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        in_reset_seq = 1'b1;
        rst = 1'b1;
        rr_op = c_op_bubble;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        in_reset_seq = 1'b0;
        issue(c_op_alur, c_alu_add, 32'h700, 32'd20, 32'd22, 32'd0, 4'd6, 1'b1, 1, sc, fl, rd_pc);
        chk("post_reset_add", ex_result, 32'd42);

        // Randomized traffic
        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 19) == 0) op = c_op_mul;
            else begin
                op = 6'($urandom_range(0, 9));
                if (op == c_op_mul) op = c_op_alur;
            end
            if (op == c_op_alur || op == c_op_alui) alt = 8'($urandom_range(0, 7));
            else if (op inside {c_op_cmpr, c_op_cmpi, c_op_br}) alt = 8'($urandom_range(0, 3));
            else alt = 8'($urandom);
            rs  = $urandom;
            rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            case ($urandom_range(0, 2))
                0: imm = 32'd0;
                1: imm = 32'($urandom_range(0, 15)) - 32'd8;
                default: imm = $urandom;
            endcase
            pc = $urandom & 32'hFFFF_FFFC;
            issue(op, alt, pc, rs, rt, imm, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), 0, sc, fl, rd_pc);
        end

        rr_op = c_op_bubble;
        mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
